// File: rtl/store_buffer.sv
// store_buffer -- write side of the data-memory path.
//
// Converts SB/SH/SW stores from the MEM stage into word-aligned writes
// (lane-replicated data plus byte enables), queues them in a DEPTH-entry
// FIFO and drains the head entry to data memory over a req/ack handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   st_valid/st_ready store request from MEM stage / buffer not full
//   st_size           00 byte, 01 half, 10 word, 11 illegal
//   st_addr, st_data  byte address, right-justified store data
//   misalign_err      one-cycle pulse after a rejected store
//   mem_req/mem_ack   head write pending / memory accepted head write
//   mem_addr, mem_wdata, mem_be  head entry (word address, lanes, enables)
//   count, empty      occupancy
//
// Handshakes: a store transfers on a rising edge where st_valid && st_ready
// (and it is aligned); the head transfers to memory on a rising edge where
// mem_req && mem_ack. While mem_req && !mem_ack the head is held stable;
// mem_ack with mem_req low is ignored.
//
// Optional feature (macro STORE_MERGE_EN): an accepted store whose word
// address matches the tail entry merges into it, provided at least two
// entries are occupied so the tail is never the head on the memory bus.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    input  logic [1:0]       st_size,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_ready,
    output logic             misalign_err,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]    addr_q  [DEPTH];
    logic [31:0]    addr_d  [DEPTH];
    logic [31:0]    wdata_q [DEPTH];
    logic [31:0]    wdata_d [DEPTH];
    logic [3:0]     be_q    [DEPTH];
    logic [3:0]     be_d    [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             misalign_q, misalign_d;

    logic             aligned;
    logic [3:0]       new_be;
    logic [31:0]      new_wdata;
    logic [31:0]      new_waddr;
    logic             push, pop, merge, alloc;
    logic [PTR_W-1:0] tail_ptr;

    assign st_ready     = (count_q != FULL_CNT);
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign misalign_err = misalign_q;
    assign mem_req      = !empty;
    // Head fields are only meaningful while a write is pending.
    assign mem_addr     = mem_req ? addr_q[rd_ptr_q]  : '0;
    assign mem_wdata    = mem_req ? wdata_q[rd_ptr_q] : '0;
    assign mem_be       = mem_req ? be_q[rd_ptr_q]    : '0;

    // Lane generation and alignment check.
    always_comb begin
        aligned   = 1'b0;
        new_be    = 4'b0000;
        new_wdata = st_data;
        new_waddr = {st_addr[31:2], 2'b00};
        case (st_size)
            2'b00: begin
                aligned   = 1'b1;
                new_be    = 4'b0001 << st_addr[1:0];
                new_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                aligned   = !st_addr[0];
                new_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                new_wdata = {2{st_data[15:0]}};
            end
            2'b10: begin
                aligned   = (st_addr[1:0] == 2'b00);
                new_be    = 4'b1111;
                new_wdata = st_data;
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
    end

    always_comb begin
        push       = st_valid && st_ready && aligned;
        pop        = mem_req && mem_ack;
        misalign_d = st_valid && st_ready && !aligned;
        tail_ptr   = wr_ptr_q - 1'b1;
`ifdef STORE_MERGE_EN
        merge      = push && (count_q >= (PTR_W + 1)'(2)) &&
                     (addr_q[tail_ptr] == new_waddr);
`else
        merge      = 1'b0;
`endif
        alloc      = push && !merge;

        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (merge) begin
            be_d[tail_ptr] = be_q[tail_ptr] | new_be;
            for (int i = 0; i < 4; i++) begin
                if (new_be[i]) begin
                    wdata_d[tail_ptr][8*i +: 8] = new_wdata[8*i +: 8];
                end
            end
        end else if (alloc) begin
            addr_d[wr_ptr_q]  = new_waddr;
            wdata_d[wr_ptr_q] = new_wdata;
            be_d[wr_ptr_q]    = new_be;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({alloc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

endmodule
